// File: rtl/mfp_ahb_sevenseg_arb.sv
// mfp_ahb_sevenseg_arb: two-requester seven-segment display ownership arbiter with minimum dwell.
// Optional B-overlay blink compiled in with MFP_SEVENSEG_BLINK_EN.
module mfp_ahb_sevenseg_arb #(
  parameter int HOLD_CYCLES = 25_000_000,
  parameter int CNT_W       = 25,
  parameter int BLINK_HALF  = 12_500_000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        REQ_A,
  input  logic [7:0]  EN_A,
  input  logic [31:0] DIGITS_A,
  input  logic        REQ_B,
  input  logic [7:0]  EN_B,
  input  logic [31:0] DIGITS_B,
  output logic        GNT_A,
  output logic        GNT_B,
  output logic [7:0]  EN_OUT,
  output logic [31:0] DIGITS_OUT
);
  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;
  localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(HOLD_CYCLES - 1);
  if (HOLD_CYCLES < 2 || BLINK_HALF < 1) begin : g_bad_cfg
    $error("mfp_ahb_sevenseg_arb: HOLD_CYCLES must be >= 2 and BLINK_HALF >= 1");
  end
  state_t            state_q, state_d;
  logic              last_b_q, last_b_d;
  logic [CNT_W-1:0]  dwell_q, dwell_d;
  logic [7:0]        en_q, en_d, b_en;
  logic [31:0]       dig_q, dig_d;
  logic              dwell_done, change;
  assign dwell_done = dwell_q == DWELL_MAX;
`ifdef MFP_SEVENSEG_BLINK_EN
  localparam logic [CNT_W-1:0] BLINK_MAX = CNT_W'(BLINK_HALF - 1);
  logic [CNT_W-1:0] blink_q, blink_d;
  logic             phase_q, phase_d, enter_b, blink_wrap;
  assign enter_b    = change && state_d == OWN_B;
  assign blink_wrap = blink_q == BLINK_MAX;
  always_comb begin
    blink_d = enter_b ? '0 : state_q == OWN_B ? (blink_wrap ? '0 : blink_q + 1'b1) : blink_q;
    phase_d = enter_b ? 1'b0 : (state_q == OWN_B && blink_wrap) ? ~phase_q : phase_q;
    b_en    = phase_d ? 8'hFF : EN_B;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      blink_q <= '0;
      phase_q <= 1'b0;
    end else begin
      blink_q <= blink_d;
      phase_q <= phase_d;
    end
`else
  assign b_en = EN_B;
`endif
  // A release (owner drops request) takes priority; preemption only fires once dwell is spent.
  always_comb begin
    state_d = state_q;
    case (state_q)
      OWN_A:   state_d = (!REQ_A || (REQ_B && dwell_done)) ? (REQ_B ? OWN_B : IDLE) : OWN_A;
      OWN_B:   state_d = (!REQ_B || (REQ_A && dwell_done)) ? (REQ_A ? OWN_A : IDLE) : OWN_B;
      default: state_d = (REQ_A && (!REQ_B || last_b_q)) ? OWN_A : REQ_B ? OWN_B : IDLE;
    endcase
    change   = state_d != state_q;
    dwell_d  = change ? '0 : (state_q != IDLE && !dwell_done) ? dwell_q + 1'b1 : dwell_q;
    last_b_d = (change && state_d != IDLE) ? state_d == OWN_B : last_b_q;
    en_d     = state_d == OWN_A ? EN_A : state_d == OWN_B ? b_en : 8'hFF;
    dig_d    = state_d == OWN_A ? DIGITS_A : state_d == OWN_B ? DIGITS_B : dig_q;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q  <= IDLE;
      last_b_q <= 1'b1;
      dwell_q  <= '0;
      en_q     <= 8'hFF;
      dig_q    <= '0;
    end else begin
      state_q  <= state_d;
      last_b_q <= last_b_d;
      dwell_q  <= dwell_d;
      en_q     <= en_d;
      dig_q    <= dig_d;
    end
  assign GNT_A      = state_q == OWN_A;
  assign GNT_B      = state_q == OWN_B;
  assign EN_OUT     = en_q;
  assign DIGITS_OUT = dig_q;
endmodule

// File: tb/tb_mfp_ahb_sevenseg_arb.sv
// tb_mfp_ahb_sevenseg_arb: scoreboard bench for the seven-segment display arbiter.
module tb_mfp_ahb_sevenseg_arb;
  localparam int HOLD = 4;
  localparam int HALF = 2;
`ifdef MFP_SEVENSEG_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif
  logic        clk = 1'b0, resetn = 1'b0, REQ_A = 1'b0, REQ_B = 1'b0;
  logic [7:0]  EN_A = 8'hFF, EN_B = 8'hFF;
  logic [31:0] DIGITS_A = '0, DIGITS_B = '0;
  logic        GNT_A, GNT_B;
  logic [7:0]  EN_OUT;
  logic [31:0] DIGITS_OUT;
  typedef struct packed {logic ga; logic gb; logic [7:0] en; logic [31:0] dig;} obs_t;
  obs_t q[$];
  int ntests = 0, nfail = 0;
  mfp_ahb_sevenseg_arb #(.HOLD_CYCLES(HOLD), .CNT_W(4), .BLINK_HALF(HALF)) dut (
    .clk(clk), .resetn(resetn),
    .REQ_A(REQ_A), .EN_A(EN_A), .DIGITS_A(DIGITS_A),
    .REQ_B(REQ_B), .EN_B(EN_B), .DIGITS_B(DIGITS_B),
    .GNT_A(GNT_A), .GNT_B(GNT_B), .EN_OUT(EN_OUT), .DIGITS_OUT(DIGITS_OUT)
  );
  always #5 clk = ~clk;
  function automatic obs_t cur();
    return {GNT_A, GNT_B, EN_OUT, DIGITS_OUT};
  endfunction
  // k counts cycles since B took ownership
  function automatic logic [7:0] b_en(int k, logic [7:0] en);
    return (BLINK && ((k / HALF) % 2 == 1)) ? 8'hFF : en;
  endfunction
  task automatic test_reset();
    obs_t o;
    repeat (2) @(posedge clk);
    #1 o = cur(); ntests++;
    if (o !== obs_t'({2'b00, 8'hFF, 32'h0})) begin nfail++; $display("FAIL reset_state: got %h want %h", o, obs_t'({2'b00, 8'hFF, 32'h0})); end
    resetn = 1'b1;
    q.push_back({2'b00, 8'hFF, 32'h0});
    @(posedge clk); #1 o = cur(); ntests++;
    if (o !== q[0]) begin nfail++; $display("FAIL idle_no_req: got %h want %h", o, q[0]); end
    void'(q.pop_front());
  endtask
  task automatic test_single();
    obs_t o, e;
    REQ_A = 1'b1; EN_A = 8'hF0; DIGITS_A = 32'h12345678;
    q.push_back({2'b10, 8'hF0, 32'h12345678});
    REQ_A = 1'b1;
    @(posedge clk); #1 o = cur(); e = q.pop_front(); ntests++;
    if (o !== e) begin nfail++; $display("FAIL single_grant: got %h want %h", o, e); end
    REQ_A = 1'b0;
    q.push_back({2'b00, 8'hFF, 32'h12345678});
    @(posedge clk); #1 o = cur(); e = q.pop_front(); ntests++;
    if (o !== e) begin nfail++; $display("FAIL single_release: got %h want %h", o, e); end
  endtask
  task automatic test_async_reset();
    obs_t o, e;
    REQ_A = 1'b1;
    q.push_back({2'b10, 8'hF0, 32'h12345678});
    @(posedge clk); #1 o = cur(); e = q.pop_front(); ntests++;
    if (o !== e) begin nfail++; $display("FAIL pre_reset_grant: got %h want %h", o, e); end
    #2 resetn = 1'b0;
    q.push_back({2'b00, 8'hFF, 32'h0});
    #1 o = cur(); e = q.pop_front(); ntests++;
    if (o !== e) begin nfail++; $display("FAIL async_reset: got %h want %h", o, e); end
    #1 resetn = 1'b1;
    q.push_back({2'b10, 8'hF0, 32'h12345678});
    @(posedge clk); #1 o = cur(); e = q.pop_front(); ntests++;
    if (o !== e) begin nfail++; $display("FAIL reset_release_grant: got %h want %h", o, e); end
    REQ_A = 1'b0;
    q.push_back({2'b00, 8'hFF, 32'h12345678});
    @(posedge clk); #1 o = cur(); e = q.pop_front(); ntests++;
    if (o !== e) begin nfail++; $display("FAIL reset_drop: got %h want %h", o, e); end
  endtask
  task automatic test_tie();
    obs_t o, e;
    resetn = 1'b0; #1 resetn = 1'b1;
    EN_A = 8'hF0; DIGITS_A = 32'hAAAA0001; EN_B = 8'h0F; DIGITS_B = 32'hBBBB0002;
    REQ_A = 1'b1; REQ_B = 1'b1;
    for (int i = 0; i < 12; i++)
      q.push_back(((i / HOLD) % 2 == 0) ? obs_t'({2'b10, 8'hF0, 32'hAAAA0001})
                                        : obs_t'({2'b01, b_en(i % HOLD, 8'h0F), 32'hBBBB0002}));
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1 o = cur(); e = q.pop_front(); ntests++;
      if (o !== e) begin nfail++; $display("FAIL tie_cycle%0d: got %h want %h", i, o, e); end
    end
    REQ_A = 1'b0; REQ_B = 1'b0;
    q.push_back({2'b00, 8'hFF, 32'hAAAA0001});
    @(posedge clk); #1 o = cur(); e = q.pop_front(); ntests++;
    if (o !== e) begin nfail++; $display("FAIL tie_idle: got %h want %h", o, e); end
  endtask
  task automatic test_early_release();
    obs_t o, e;
    REQ_A = 1'b1;
    q.push_back({2'b10, 8'hF0, 32'hAAAA0001});
    @(posedge clk); #1 o = cur(); e = q.pop_front(); ntests++;
    if (o !== e) begin nfail++; $display("FAIL early_grant_a: got %h want %h", o, e); end
    REQ_B = 1'b1;
    q.push_back({2'b10, 8'hF0, 32'hAAAA0001});
    @(posedge clk); #1 o = cur(); e = q.pop_front(); ntests++;
    if (o !== e) begin nfail++; $display("FAIL early_hold_a: got %h want %h", o, e); end
    REQ_A = 1'b0;
    q.push_back({2'b01, b_en(0, 8'h0F), 32'hBBBB0002});
    @(posedge clk); #1 o = cur(); e = q.pop_front(); ntests++;
    if (o !== e) begin nfail++; $display("FAIL early_handoff_b: got %h want %h", o, e); end
    REQ_B = 1'b0;
    q.push_back({2'b00, 8'hFF, 32'hBBBB0002});
    @(posedge clk); #1 o = cur(); e = q.pop_front(); ntests++;
    if (o !== e) begin nfail++; $display("FAIL early_idle: got %h want %h", o, e); end
  endtask
  task automatic test_blink();
    obs_t o, e;
    EN_B = 8'h00; REQ_B = 1'b1;
    for (int k = 0; k < 8; k++) q.push_back({2'b01, b_en(k, 8'h00), 32'hBBBB0002});
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1 o = cur(); e = q.pop_front(); ntests++;
      if (o !== e) begin nfail++; $display("FAIL blink_cycle%0d: got %h want %h", k, o, e); end
    end
    REQ_B = 1'b0;
    q.push_back({2'b00, 8'hFF, 32'hBBBB0002});
    @(posedge clk); #1 o = cur(); e = q.pop_front(); ntests++;
    if (o !== e) begin nfail++; $display("FAIL blink_idle: got %h want %h", o, e); end
  endtask
  task automatic test_tracking();
    obs_t o, e;
    REQ_A = 1'b1; EN_A = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      DIGITS_A = $urandom;
      q.push_back({2'b10, 8'h3C, DIGITS_A});
      @(posedge clk); #1 o = cur(); e = q.pop_front(); ntests++;
      if (o !== e) begin nfail++; $display("FAIL track_cycle%0d: got %h want %h", i, o, e); end
    end
    REQ_A = 1'b0;
    q.push_back({2'b00, 8'hFF, DIGITS_A});
    @(posedge clk); #1 o = cur(); e = q.pop_front(); ntests++;
    if (o !== e) begin nfail++; $display("FAIL track_idle: got %h want %h", o, e); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_async_reset();
    test_tie();
    test_early_release();
    test_blink();
    test_tracking();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/mfp_ahb_sevenseg_arb.md
# mfp_ahb_sevenseg_arb

Display-ownership arbiter for the Nexys4 DDR eight-digit seven-segment display. Two requesters share the display: A, the software display register, and B, an overlay source such as a fault or status code. The block grants the display to one requester at a time and holds each grant for a human-readable minimum dwell. It drives the `EN`/`DIGITS` inputs of `mfp_ahb_sevensegtimer` from the current owner's registered data.

## Interface
- `HOLD_CYCLES`, default 25_000_000: minimum dwell before the owner can be preempted (0.5 s at 50 MHz). Legal range is ≥ 2.
- `CNT_W`, default 25: width of the dwell and blink counters. Must satisfy 2^CNT_W > max(HOLD_CYCLES, BLINK_HALF).
- `BLINK_HALF`, default 12_500_000: half-period of the B blink, in cycles. Used only when the blink feature is compiled in.
- `clk` input 1: system clock. One clock domain.
- `resetn` input 1: asynchronous, active-low reset.
- `REQ_A` input 1: requester A wants the display.
- `EN_A` input 8: A's digit enables. Active-low: bit i = 0 lights digit i.
- `DIGITS_A` input 32: A's eight nibbles. Digit i is `[4i+3:4i]`.
- `REQ_B`, `EN_B`, `DIGITS_B`: same definitions for requester B.
- `GNT_A` output 1: A currently owns the display.
- `GNT_B` output 1: B currently owns the display.
- `EN_OUT` output 8: connects to the timer's `EN` input.
- `DIGITS_OUT` output 32: connects to the timer's `DIGITS` input.

## Operation
- The FSM has three states: IDLE, OWN_A and OWN_B. All outputs are registered.
- Reset state:
  - FSM in IDLE.
  - `GNT_A` = `GNT_B` = 0.
  - `EN_OUT` = 8'hFF (all digits blank).
  - `DIGITS_OUT` = 0.
  - Dwell counter = 0.
  - Last-served pointer = B, so A wins the first tie.
- IDLE:
  - Only one request asserted: grant it.
  - Both requests asserted: grant the requester that was not served last.
  - No requests: stay in IDLE with outputs blank.
- OWN_x:
  - Each cycle, `EN_OUT`/`DIGITS_OUT` load `EN_x`/`DIGITS_x` (one-cycle pass-through).
  - Dwell counter increments and saturates at HOLD_CYCLES-1.
- Release: the owner drops its request. Move to OWN_other if the other requester is asserting, otherwise to IDLE. Dwell is ignored on release.
- Preemption: the other requester is asserting and dwell = HOLD_CYCLES-1. Switch to OWN_other even though the owner is still requesting. This gives round-robin fairness.
- On every grant change:
  - Dwell counter clears to 0.
  - Last-served pointer is updated to the new owner.
- Entering IDLE: `EN_OUT` = 8'hFF and `DIGITS_OUT` holds its last value.
- `GNT_A` and `GNT_B` are never high together. Every transition between owners is direct; there is no IDLE gap.

## Timing
- Requests are sampled at a rising edge. The corresponding `GNT` and first owner data appear after that same edge, so grant latency is 1 cycle from request.
- Data latency: `EN_OUT`/`DIGITS_OUT` = owner inputs delayed 1 cycle.
- A grant lasts at least 1 cycle. If the owner keeps requesting while the other requests, it holds for exactly HOLD_CYCLES cycles before the switch.
- Request drop and preemption in the same cycle: release rules apply, and the result is identical.
- Asynchronous reset mid-grant: `GNT` drops and `EN_OUT` blanks immediately, with no clock edge needed.

## Configuration
- Macro: `MFP_SEVENSEG_BLINK_EN`.
- Defined:
  - While in OWN_B, the blink counter toggles a phase bit every BLINK_HALF cycles.
  - Phase 1 forces `EN_OUT` = 8'hFF; phase 0 passes `EN_B`.
  - The blink counter and phase clear to 0 on entry to OWN_B and on reset.
  - OWN_A output is unaffected.
- Not defined: the blink counter is absent and B is displayed steadily.

## Test plan
Bench parameters: HOLD_CYCLES=4, BLINK_HALF=2.

1. Reset check: assert `resetn` low mid-simulation with `REQ_A` = 1 → `GNT_A`=0, `EN_OUT`=8'hFF, `DIGITS_OUT`=0 asynchronously. Release reset → `GNT_A`=1 one edge later.
2. Single requester: `REQ_A`=1, `EN_A`=8'hF0, `DIGITS_A`=32'h12345678 → after 1 edge, `GNT_A`=1, `EN_OUT`=8'hF0, `DIGITS_OUT`=32'h12345678. Drop `REQ_A` → IDLE, `EN_OUT`=8'hFF after 1 edge.
3. Tie after reset: `REQ_A`=`REQ_B`=1 on the same edge → A granted first. Both held → `GNT_B` rises exactly 4 cycles after `GNT_A`, then alternation continues with a 4-cycle period.
4. Early release: A owns and `REQ_B` rises. `REQ_A` drops at dwell 1 → `GNT_B`=1 on the next edge, with no IDLE cycle and no overlap of `GNT_A`/`GNT_B`.
5. Blink with macro defined: B owns with `EN_B`=8'h00 → `EN_OUT` sequence 00,00,FF,FF,00,… Without the macro → constant 00.
6. Input tracking: A owns and `DIGITS_A` changes every cycle → `DIGITS_OUT` follows with exactly 1-cycle lag; `GNT` stays stable.
